// File: rtl/vbuffer_pingpong_pkg.sv
// Shared definitions for the ping-pong video line buffer.
// Default widths and the write-side fill state encoding.
package vbuffer_pingpong_pkg;

  localparam int IWIDTH_D = 2;
  localparam int BPP_D    = 6;
  localparam int DWIDTH_D = 8;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } wstate_e;

  // Index of the final slot in a bank of 2**iw entries
  function automatic int last_slot(input int iw);
    return (1 << iw) - 1;
  endfunction

endpackage

// File: rtl/vbuffer_bank.sv
// One pixel bank: PSIZE x BPP register array.
// Ports: Clk, We/WAddr/WData sync write, RAddr -> RData comb read.
module vbuffer_bank #(
  parameter int IWIDTH = 2,
  parameter int BPP    = 6
) (
  input  logic              Clk,
  input  logic              We,
  input  logic [IWIDTH-1:0] WAddr,
  input  logic [BPP-1:0]    WData,
  input  logic [IWIDTH-1:0] RAddr,
  output logic [BPP-1:0]    RData
);

  localparam int PSIZE = 2 ** IWIDTH;

  logic [BPP-1:0] mem [PSIZE];

  always_ff @(posedge Clk) begin
    if (We) mem[WAddr] <= WData;
  end

  assign RData = mem[RAddr];

endmodule

// File: rtl/vbuffer_pingpong.sv
// Double-buffered line buffer between the fetch stream and VGA output.
// Ports: Clk, Reset, Write/DataIn/WriteReady, LineEnd, Blank,
//        ReadIndex, VideoOut (registered), Underrun (1-cycle pulse).
module vbuffer_pingpong
  import vbuffer_pingpong_pkg::*;
#(
  parameter int IWIDTH = IWIDTH_D,
  parameter int BPP    = BPP_D,
  parameter int DWIDTH = DWIDTH_D
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Write,
  input  logic [DWIDTH-1:0] DataIn,
  output logic              WriteReady,
  input  logic              LineEnd,
  input  logic              Blank,
  input  logic [IWIDTH-1:0] ReadIndex,
  output logic [BPP-1:0]    VideoOut,
  output logic              Underrun
);

  localparam logic [IWIDTH-1:0] LAST =
    IWIDTH'(last_slot(IWIDTH));

  wstate_e           state;
  logic [IWIDTH-1:0] wptr;
  logic              wrbank;
  logic              rdvalid;

  logic              wr_acc;
  logic              wr_last;
  logic              full_now;
  logic [BPP-1:0]    pix;
  logic              we0;
  logic              we1;
  logic [BPP-1:0]    rd0;
  logic [BPP-1:0]    rd1;
  logic [BPP-1:0]    rdata;

  assign pix        = DataIn[BPP-1:0];
  assign WriteReady = (state == ST_FILL);
  assign wr_acc     = Write & WriteReady;
  assign wr_last    = wr_acc & (wptr == LAST);
  // A final write landing in this same cycle still counts as full
  assign full_now   = (state == ST_FULL) | wr_last;

  assign we0 = wr_acc & ~wrbank;
  assign we1 = wr_acc &  wrbank;

  // Display bank is always the one not being written
  assign rdata = wrbank ? rd0 : rd1;

  generate
    if (DWIDTH > BPP) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^DataIn[DWIDTH-1:BPP];
    end
  endgenerate

  vbuffer_bank #(
    .IWIDTH (IWIDTH),
    .BPP    (BPP)
  ) u_bank0 (
    .Clk   (Clk),
    .We    (we0),
    .WAddr (wptr),
    .WData (pix),
    .RAddr (ReadIndex),
    .RData (rd0)
  );

  vbuffer_bank #(
    .IWIDTH (IWIDTH),
    .BPP    (BPP)
  ) u_bank1 (
    .Clk   (Clk),
    .We    (we1),
    .WAddr (wptr),
    .WData (pix),
    .RAddr (ReadIndex),
    .RData (rd1)
  );

  // Write FSM, bank select and swap
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= ST_FILL;
      wptr     <= '0;
      wrbank   <= 1'b0;
      rdvalid  <= 1'b0;
      Underrun <= 1'b0;
    end else begin
      Underrun <= 1'b0;
      if (LineEnd && full_now) begin
        wrbank  <= ~wrbank;
        state   <= ST_FILL;
        wptr    <= '0;
        rdvalid <= 1'b1;
      end else begin
        if (LineEnd) begin
          rdvalid  <= 1'b0;
          Underrun <= 1'b1;
        end
        if (wr_acc) begin
          // Wraps to zero naturally on the last slot
          wptr <= wptr + 1'b1;
          if (wr_last) state <= ST_FULL;
        end
      end
    end
  end

  // Output register sees the pre-swap display bank
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      VideoOut <= '0;
    end else if (Blank || !rdvalid) begin
      VideoOut <= '0;
    end else begin
      VideoOut <= rdata;
    end
  end

endmodule
